// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - architectural register file and write-back stage around the ALU
//
// Purpose:
//   Holds 2**D words of W bits. The two combinational read ports feed the ALU A/B
//   operands. A single synchronous write port captures the ALU result. A flag
//   register latches carry/zero/parity; its carry bit feeds back to the ALU.
//   The block also keeps a saturating count of committed register writes.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset (dominates everything)
//   hold                - pipeline stall; blocks all register, flag and counter updates
//   rd_addrA/rd_addrB   - read addresses; datA_out/datB_out are combinational data
//   wr_en/wr_addr/wr_data - register write request
//   flag_we, sc_in, zero_in, pari_in - flag update request and ALU flag inputs
//   sc_q, zero_q, pari_q - registered flags
//   wr_count            - committed register writes since reset, saturates at 255
module reg_file_wb #(
  parameter int D      = 3,
  parameter int W      = 8,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic [D-1:0] rd_addrA,
  input  logic [D-1:0] rd_addrB,
  output logic [W-1:0] datA_out,
  output logic [W-1:0] datB_out,
  input  logic         wr_en,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         flag_we,
  input  logic         sc_in,
  input  logic         zero_in,
  input  logic         pari_in,
  output logic         sc_q,
  output logic         zero_q,
  output logic         pari_q,
  output logic [7:0]   wr_count
);

  localparam int NREGS = 2 ** D;

  logic [W-1:0] r_mem [NREGS];
  logic         r_sc;
  logic         r_zero;
  logic         r_pari;
  logic [7:0]   r_wr_count;

  logic w_wr_commit;
  logic w_flag_commit;
  logic w_byp_a;
  logic w_byp_b;

  // A write only lands when nothing (stall or reset) blocks it; the bypass uses
  // the same condition so a blocked write is never forwarded to the ALU.
  assign w_wr_commit   = wr_en & ~hold & ~reset;
  assign w_flag_commit = flag_we & ~hold & ~reset;

  assign w_byp_a = (BYPASS != 0) && w_wr_commit && (wr_addr == rd_addrA);
  assign w_byp_b = (BYPASS != 0) && w_wr_commit && (wr_addr == rd_addrB);

  assign datA_out = w_byp_a ? wr_data : r_mem[rd_addrA];
  assign datB_out = w_byp_b ? wr_data : r_mem[rd_addrB];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
      r_sc       <= 1'b0;
      r_zero     <= 1'b0;
      r_pari     <= 1'b0;
      r_wr_count <= 8'd0;
    end else begin
      if (w_wr_commit) begin
        r_mem[wr_addr] <= wr_data;
        if (r_wr_count != 8'hFF) begin
          r_wr_count <= r_wr_count + 8'd1;
        end
      end
      if (w_flag_commit) begin
        r_sc   <= sc_in;
        r_zero <= zero_in;
        r_pari <= pari_in;
      end
    end
  end

  assign sc_q     = r_sc;
  assign zero_q   = r_zero;
  assign pari_q   = r_pari;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - directed self-checking bench for reg_file_wb (BYPASS=1 and BYPASS=0)
module tb_reg_file_wb;

  logic       clk;
  logic       reset;
  logic       hold;
  logic [2:0] rd_addrA;
  logic [2:0] rd_addrB;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       flag_we;
  logic       sc_in;
  logic       zero_in;
  logic       pari_in;

  logic [7:0] datA, datB, datA0, datB0;
  logic       sc, zero, pari, sc0, zero0, pari0;
  logic [7:0] cnt, cnt0;

  int tests_run = 0;
  int fails     = 0;

  reg_file_wb #(.D(3), .W(8), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA), .datB_out(datB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .sc_in(sc_in), .zero_in(zero_in), .pari_in(pari_in),
    .sc_q(sc), .zero_q(zero), .pari_q(pari), .wr_count(cnt)
  );

  reg_file_wb #(.D(3), .W(8), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .hold(hold),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA0), .datB_out(datB0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .sc_in(sc_in), .zero_in(zero_in), .pari_in(pari_in),
    .sc_q(sc0), .zero_q(zero0), .pari_q(pari0), .wr_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addrA = 3'(i);
      rd_addrB = 3'(7 - i);
      #1;
      tests_run++;
      if (datA !== 8'h00 || datB !== 8'h00 || datA0 !== 8'h00 || datB0 !== 8'h00) begin
        fails++;
        $display("FAIL reset_read[%0d]: got A=%h B=%h A0=%h B0=%h expected 00", i, datA, datB, datA0, datB0);
      end
    end
    tests_run++;
    if ({sc, zero, pari, sc0, zero0, pari0} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b%b%b/%b%b%b expected 000/000", sc, zero, pari, sc0, zero0, pari0);
    end
    tests_run++;
    if (cnt !== 8'd0 || cnt0 !== 8'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d/%0d expected 0", cnt, cnt0);
    end
  endtask

  task automatic test_write_readback();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    wr_addr = 3'd7; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    rd_addrA = 3'd3; rd_addrB = 3'd7;
    #1;
    tests_run++;
    if (datA !== 8'hA5 || datB !== 8'h3C || datA0 !== 8'hA5 || datB0 !== 8'h3C) begin
      fails++;
      $display("FAIL readback: got A=%h B=%h A0=%h B0=%h expected A5 3C", datA, datB, datA0, datB0);
    end
    tests_run++;
    if (cnt !== 8'd2 || cnt0 !== 8'd2) begin
      fails++;
      $display("FAIL readback_count: got %0d/%0d expected 2", cnt, cnt0);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    tick();
    wr_data = 8'h99;
    rd_addrA = 3'd2; rd_addrB = 3'd2;
    #1;
    tests_run++;
    if (datA !== 8'h99 || datB !== 8'h99) begin
      fails++;
      $display("FAIL bypass_on: got A=%h B=%h expected 99 99", datA, datB);
    end
    tests_run++;
    if (datA0 !== 8'h11 || datB0 !== 8'h11) begin
      fails++;
      $display("FAIL bypass_off_before: got A=%h B=%h expected 11 11", datA0, datB0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    tests_run++;
    if (datA !== 8'h99 || datB !== 8'h99 || datA0 !== 8'h99 || datB0 !== 8'h99) begin
      fails++;
      $display("FAIL bypass_after: got A=%h B=%h A0=%h B0=%h expected 99", datA, datB, datA0, datB0);
    end
    tests_run++;
    if (cnt !== 8'd4) begin
      fails++;
      $display("FAIL bypass_count: got %0d expected 4", cnt);
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hFF;
    flag_we = 1'b1; sc_in = 1'b1; zero_in = 1'b0; pari_in = 1'b0;
    rd_addrA = 3'd5; rd_addrB = 3'd3;
    #1;
    tests_run++;
    if (datA !== 8'h00) begin
      fails++;
      $display("FAIL hold_no_bypass: got %h expected 00", datA);
    end
    tick();
    tests_run++;
    if (datA !== 8'h00 || datA0 !== 8'h00 || sc !== 1'b0 || cnt !== 8'd4) begin
      fails++;
      $display("FAIL hold_blocked: got r5=%h r5_0=%h sc=%b cnt=%0d expected 00 00 0 4", datA, datA0, sc, cnt);
    end
    hold = 1'b0;
    #1;
    tests_run++;
    if (datA !== 8'hFF) begin
      fails++;
      $display("FAIL release_bypass: got %h expected ff", datA);
    end
    tick();
    wr_en = 1'b0; flag_we = 1'b0; sc_in = 1'b0;
    #1;
    tests_run++;
    if (datA !== 8'hFF || datA0 !== 8'hFF || sc !== 1'b1 || cnt !== 8'd5) begin
      fails++;
      $display("FAIL release_commit: got r5=%h r5_0=%h sc=%b cnt=%0d expected ff ff 1 5", datA, datA0, sc, cnt);
    end
  endtask

  task automatic test_flags_reset();
    flag_we = 1'b1; sc_in = 1'b1; zero_in = 1'b0; pari_in = 1'b1;
    rd_addrA = 3'd3; rd_addrB = 3'd7;
    tick();
    flag_we = 1'b0; sc_in = 1'b0; pari_in = 1'b0;
    #1;
    tests_run++;
    if ({sc, zero, pari} !== 3'b101 || {sc0, zero0, pari0} !== 3'b101) begin
      fails++;
      $display("FAIL flags_only: got %b%b%b/%b%b%b expected 101", sc, zero, pari, sc0, zero0, pari0);
    end
    tests_run++;
    if (datA !== 8'hA5 || datB !== 8'h3C || cnt !== 8'd5) begin
      fails++;
      $display("FAIL flags_only_regs: got A=%h B=%h cnt=%0d expected a5 3c 5", datA, datB, cnt);
    end
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h42;
    rd_addrA = 3'd1;
    #1;
    tests_run++;
    if (datA !== 8'h00) begin
      fails++;
      $display("FAIL reset_no_bypass: got %h expected 00", datA);
    end
    tick();
    reset = 1'b0; wr_en = 1'b0;
    #1;
    tests_run++;
    if (datA !== 8'h00 || datB !== 8'h00 || {sc, zero, pari} !== 3'b000 || cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_priority: got r1=%h r7=%h flags=%b%b%b cnt=%0d expected 00 00 000 0", datA, datB, sc, zero, pari, cnt);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h12;
    tick();
    wr_data = 8'h34;
    tick();
    wr_addr = 3'd0; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_addrA = 3'd4; rd_addrB = 3'd0;
    #1;
    tests_run++;
    if (datA !== 8'h34 || datA0 !== 8'h34) begin
      fails++;
      $display("FAIL last_wins: got %h/%h expected 34", datA, datA0);
    end
    tests_run++;
    if (datB !== 8'h77) begin
      fails++;
      $display("FAIL r0_writable: got %h expected 77", datB);
    end
    tests_run++;
    if (cnt !== 8'd3) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 3", cnt);
    end
  endtask

  task automatic test_saturation();
    wr_en = 1'b1;
    for (int i = 0; i < 251; i++) begin
      wr_addr = 3'(i);
      wr_data = 8'(i);
      tick();
    end
    tests_run++;
    if (cnt !== 8'd254) begin
      fails++;
      $display("FAIL count_254: got %0d expected 254", cnt);
    end
    tick();
    tests_run++;
    if (cnt !== 8'd255) begin
      fails++;
      $display("FAIL count_255: got %0d expected 255", cnt);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
    end
    wr_en = 1'b0;
    #1;
    tests_run++;
    if (cnt !== 8'd255 || cnt0 !== 8'd255) begin
      fails++;
      $display("FAIL count_saturated: got %0d/%0d expected 255", cnt, cnt0);
    end
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0;
    rd_addrA = '0; rd_addrB = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    flag_we = 1'b0; sc_in = 1'b0; zero_in = 1'b0; pari_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_readback();
    test_bypass();
    test_hold();
    test_flags_reset();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file and write-back stage for the 8-bit datapath.
- Sits directly around the ALU:
  - supplies the ALU A/B operands from two combinational read ports;
  - captures the ALU result on a single synchronous write port;
  - latches the ALU carry/zero/parity outputs into a flag register, whose carry bit feeds back as the ALU shift/carry input.
- Supports a pipeline hold and optional same-cycle write-to-read bypass.

Parameters:
- D, 3: register address width (2**D registers).
- W, 8: data width.
- BYPASS, 1: 1 = a read of the address being written this cycle returns the write data; 0 = the read returns the stored (old) value.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  pipeline stall; suppresses all register and flag updates
- rd_addrA  in  D  read port A address (ALU operand A)
- rd_addrB  in  D  read port B address (ALU operand B)
- datA_out  out  W  read port A data
- datB_out  out  W  read port B data
- wr_en  in  1  register write enable
- wr_addr  in  D  write address (destination register)
- wr_data  in  W  write data (ALU result or load data)
- flag_we  in  1  flag register update enable
- sc_in  in  1  carry/shift-out from ALU
- zero_in  in  1  zero flag from ALU
- pari_in  in  1  parity flag from ALU
- sc_q  out  1  registered carry, drives ALU shift/carry input
- zero_q  out  1  registered zero flag (branch condition source)
- pari_q  out  1  registered parity flag
- wr_count  out  8  number of committed register writes since reset, saturating

Behaviour:
- Storage: 2**D words of W bits; flag register {sc_q, zero_q, pari_q}; wr_count counter.
- Reset (reset=1 at a rising clk edge):
  - all registers, sc_q, zero_q, pari_q and wr_count go to 0;
  - reset dominates wr_en, flag_we and hold;
  - asserting reset mid-stream discards any write presented in that cycle.
  - Before the first reset edge, contents are undefined; the bench must reset first.
- Commit condition: a write commits at a rising edge when wr_en=1, hold=0 and reset=0.
  - The new value is visible in storage from the next cycle (1-cycle write latency).
- Reads are combinational from rd_addr*, with 0-cycle latency.
  - BYPASS=1 and a pending commit with wr_addr==rd_addrX: datX_out = wr_data.
  - Otherwise datX_out = stored word.
  - Both ports may read the same address, and both may bypass simultaneously.
  - hold=1 disables bypass, because no write commits that cycle.
- Flags update at a rising edge when flag_we=1, hold=0 and reset=0:
  - sc_q<=sc_in, zero_q<=zero_in, pari_q<=pari_in;
  - otherwise the flags hold their value.
  - Flags are never bypassed: sc_q reflects the previous committed update.
- Register write and flag update are independent.
  - Both may occur in the same cycle, and either may occur alone.
- wr_count:
  - increments by 1 on each committed write;
  - saturates at 255 (no wrap);
  - unaffected by flag updates and by hold cycles.
- Two writes in consecutive cycles to the same address: the last one wins, and each counts.
- Out-of-range addresses cannot occur (the address width is exactly D).
- No register is hardwired; register 0 is fully writable.
- Any X on wr_en or flag_we when reset=0 is a bench error and must not be relied upon.

Test Plan:
- Reset then read: after reset, read all 8 addresses on both ports -> every read returns 0x00; sc_q=zero_q=pari_q=0; wr_count=0.
- Write/readback: write 0xA5 to r3, then 0x3C to r7 on successive edges; next cycle set rd_addrA=3, rd_addrB=7 -> datA_out=0xA5, datB_out=0x3C; wr_count=2.
- Bypass: r2 holds 0x11; in the same cycle, wr_en=1, wr_addr=2, wr_data=0x99, rd_addrA=rd_addrB=2.
  - BYPASS=1 -> both outputs are 0x99 before the edge.
  - BYPASS=0 -> both outputs are 0x11 before the edge and 0x99 after it.
- Hold: hold=1 with wr_en=1 (r5 <- 0xFF) and flag_we=1 (sc_in=1) -> r5 unchanged, sc_q stays 0, wr_count unchanged; the same stimulus with hold=0 commits r5=0xFF and sc_q=1.
- Flags-only and reset priority:
  - flag_we=1 with {sc,zero,pari}={1,0,1} and wr_en=0 -> flags become 1/0/1 and no register changes.
  - Next cycle, reset=1 together with wr_en=1 (r1 <- 0x42) -> r1=0x00 and all flags are 0.
- Counter saturation: 300 consecutive committed writes -> wr_count reads 255 and stays 255 after further writes.
